irq_gateway: RTL and testbench

- Platform-side interrupt source for the core: it collects 14 raw peripheral interrupt lines and drives the core's `INT_BUS` interrupt-flag input.
- Per-source functions: synchronisation, edge/level qualification, pending latch, enable mask.
- Presents one source at a time, one-hot, lowest index = highest priority.
- Software identifies the source by a claim read and ends service by a complete write, both over a simple register bus.

---
 rtl/irq_gateway.sv | 242 ++++++++++++++++++++++++
 tb/tb_irq_gateway.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_gateway.sv
// -----------------------------------------------------------------------------
// irq_gateway
//
// Platform interrupt gateway. Collects NUM_SRC raw peripheral interrupt lines
// and presents at most one of them to the core as a one-hot flag vector.
// Each source is qualified (level or rising edge), latched into PENDING and
// masked by ENABLE. The lowest index wins priority. Software takes a source
// with a CLAIM read and ends service with a CLAIM write of the same ID.
//
// Optional build macro:
//   IRQ_GW_SYNC_EN  when defined, every irq_src_i bit passes through a 2-flop
//                   synchroniser (asynchronous peripherals). When undefined,
//                   irq_src_i is used directly and must be synchronous to clk.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active-low
//   irq_src_i    raw peripheral interrupt lines [NUM_SRC]
//   sel_i        register access request, one cycle per access
//   we_i         1 = write, 0 = read
//   addr_i       byte offset; bits [3:2] select the register
//   wdata_i      write data
//   rdata_o      registered read data
//   ack_o        access done, one cycle after sel_i
//   int_flag_o   one-hot interrupt request to the core [NUM_SRC]
//   dbg_state_o  current FSM state (IDLE=0, ASSERT=1, CLAIMED=2)
//
// Register map (addr_i[3:2]):
//   0x0 PENDING  read; W1C on edge-mode bits, level-mode bits ignore writes
//   0x4 ENABLE   RW
//   0x8 TRIGGER  RW; 1 = rising edge, 0 = level
//   0xC CLAIM    read = claim (ID = index+1, 0 = none), write = complete
//   Bits 31:NUM_SRC read as 0.
//
// Bus handshake: there is no back-pressure. A request is accepted on every
// clock edge where sel_i=1; a write takes effect at that edge, and ack_o is
// high for exactly one cycle after it with rdata_o valid in that same cycle
// (rdata_o is 0 in every cycle that does not follow a read).
// -----------------------------------------------------------------------------
module irq_gateway #(
    parameter int NUM_SRC = 14,
    parameter int CLAIM_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               sel_i,
    input  logic               we_i,
    input  logic [3:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               ack_o,
    output logic [NUM_SRC-1:0] int_flag_o,
    output logic [1:0]         dbg_state_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_CLAIMED = 2'd2;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_TRIGGER = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] trigger_q;
    logic [1:0]         state_q, state_d;
    logic [CLAIM_W-1:0] claimed_id_q, claimed_id_d;

    logic [NUM_SRC-1:0] masked;
    logic [NUM_SRC-1:0] cand_onehot;
    logic [CLAIM_W-1:0] cand_idx;
    logic [CLAIM_W-1:0] cand_id;
    logic               cand_valid;

    logic               wr_en, rd_en;
    logic [1:0]         reg_idx;
    logic               claim_rd, claim_wr;
    logic [NUM_SRC-1:0] edge_set, clr_mask;

    // Address byte-lane bits and upper data bits carry no meaning here.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{addr_i[1:0], wdata_i[31:NUM_SRC]};

    // ------------------------------------------------------------------
    // Source synchronisation
    // ------------------------------------------------------------------
`ifdef IRQ_GW_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src_s = sync_q2;
`else
    assign src_s = irq_src_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= src_s;
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign wr_en   = sel_i & we_i;
    assign rd_en   = sel_i & ~we_i;
    assign reg_idx = addr_i[3:2];

    // ------------------------------------------------------------------
    // Candidate selection: lowest set index of PENDING & ENABLE.
    // Scanning from the top down lets the lowest index overwrite last.
    // ------------------------------------------------------------------
    always_comb begin
        masked      = pending_q & enable_q;
        cand_valid  = |masked;
        cand_idx    = '0;
        cand_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                cand_idx       = CLAIM_W'(i);
                cand_onehot    = '0;
                cand_onehot[i] = 1'b1;
            end
        end
    end

    assign cand_id = cand_idx + CLAIM_W'(1);

    // A claim only counts when a source is actually being presented; the
    // candidate sampled at this edge is the one returned and cleared.
    assign claim_rd = rd_en && (reg_idx == REG_CLAIM) &&
                      (state_q == ST_ASSERT) && cand_valid;
    assign claim_wr = wr_en && (reg_idx == REG_CLAIM);

    // ------------------------------------------------------------------
    // Pending update. Level bits mirror the source; edge bits set on a
    // rising edge and clear on W1C or claim, with set taking priority.
    // ------------------------------------------------------------------
    assign edge_set = src_s & ~prev_q;

    always_comb begin
        clr_mask = '0;
        if (wr_en && (reg_idx == REG_PENDING)) clr_mask = wdata_i[NUM_SRC-1:0];
        if (claim_rd)                          clr_mask = clr_mask | cand_onehot;
        pending_d = (trigger_q & (edge_set | (pending_q & ~clr_mask))) |
                    (~trigger_q & src_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q  <= '0;
            trigger_q <= '0;
        end else if (wr_en) begin
            if (reg_idx == REG_ENABLE)  enable_q  <= wdata_i[NUM_SRC-1:0];
            if (reg_idx == REG_TRIGGER) trigger_q <= wdata_i[NUM_SRC-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Presentation FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        claimed_id_d = claimed_id_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_valid) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (claim_rd) begin
                    state_d      = ST_CLAIMED;
                    claimed_id_d = cand_id;
                end else if (!cand_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLAIMED: begin
                // Completion must name the claimed source; anything else is
                // dropped so a stray write cannot end service early.
                if (claim_wr && (wdata_i[CLAIM_W-1:0] == claimed_id_q)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            claimed_id_q <= '0;
        end else begin
            state_q      <= state_d;
            claimed_id_q <= claimed_id_d;
        end
    end

    // Flag is live in ASSERT so a higher-priority arrival preempts at once.
    assign int_flag_o  = (state_q == ST_ASSERT) ? cand_onehot : '0;
    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Read data and acknowledge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o <= '0;
            ack_o   <= 1'b0;
        end else begin
            ack_o <= sel_i;
            if (rd_en) begin
                case (reg_idx)
                    REG_PENDING: rdata_o <= 32'(pending_q);
                    REG_ENABLE:  rdata_o <= 32'(enable_q);
                    REG_TRIGGER: rdata_o <= 32'(trigger_q);
                    default:     rdata_o <= claim_rd ? 32'(cand_id) : '0;
                endcase
            end else begin
                rdata_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_irq_gateway.sv
// -----------------------------------------------------------------------------
// tb_irq_gateway
//
// Self-checking bench for irq_gateway. Every task starts and ends at a falling
// clock edge: inputs are driven there and outputs are sampled there, half a
// cycle away from the active rising edge. Read data expectations go through
// exp_q and are popped when the access is acknowledged.
// -----------------------------------------------------------------------------
module tb_irq_gateway;

    localparam int NUM_SRC = 14;
    localparam int CLAIM_W = 4;
`ifdef IRQ_GW_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    // Raw edge to int_flag_o when the FSM starts in IDLE.
    localparam int LAT_IDLE = 2 + SYNC;

    localparam logic [3:0] A_PENDING = 4'h0;
    localparam logic [3:0] A_ENABLE  = 4'h4;
    localparam logic [3:0] A_TRIGGER = 4'h8;
    localparam logic [3:0] A_CLAIM   = 4'hC;

    logic               clk;
    logic               rst_n;
    logic [NUM_SRC-1:0] irq_src_i;
    logic               sel_i;
    logic               we_i;
    logic [3:0]         addr_i;
    logic [31:0]        wdata_i;
    logic [31:0]        rdata_o;
    logic               ack_o;
    logic [NUM_SRC-1:0] int_flag_o;
    logic [1:0]         dbg_state_o;

    int tests;
    int fails;
    logic [31:0] exp_q[$];
    logic        last_ack;

    irq_gateway #(.NUM_SRC(NUM_SRC), .CLAIM_W(CLAIM_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_src_i   (irq_src_i),
        .sel_i       (sel_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .ack_o       (ack_o),
        .int_flag_o  (int_flag_o),
        .dbg_state_o (dbg_state_o)
    );

    // ------------------------------------------------------------------
    // Clock and reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n     = 1'b0;
        irq_src_i = '0;
        sel_i     = 1'b0;
        we_i      = 1'b0;
        addr_i    = '0;
        wdata_i   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        @(negedge clk);
        last_ack = ack_o;
        sel_i    = 1'b0;
        we_i     = 1'b0;
        wdata_i  = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        sel_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        @(negedge clk);
        last_ack = ack_o;
        d        = rdata_o;
        sel_i    = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] rd, exp;
        apply_reset();
        tests++;
        if (int_flag_o !== '0 || ack_o !== 1'b0 || rdata_o !== '0 || dbg_state_o !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs: flag=%h ack=%b rdata=%h state=%0d, expected all 0",
                     int_flag_o, ack_o, rdata_o, dbg_state_o);
        end
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back(32'h0);
            bus_read(4'(r * 4), rd);
            exp = exp_q.pop_front();
            tests++;
            if (rd !== exp || last_ack !== 1'b1) begin
                fails++;
                $display("FAIL reset_reg%0d: got %h ack=%b, expected %h ack=1", r, rd, last_ack, exp);
            end
        end
    endtask

    task automatic test_level();
        logic [31:0] rd, exp;
        int cnt;
        apply_reset();
        bus_write(A_ENABLE, 32'h0001);
        irq_src_i[0] = 1'b1;
        cnt = 0;
        while (int_flag_o === '0 && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        tests++;
        if (cnt !== LAT_IDLE || int_flag_o !== 14'h0001) begin
            fails++;
            $display("FAIL level_latency: got %0d cycles flag=%h, expected %0d cycles flag=0001",
                     cnt, int_flag_o, LAT_IDLE);
        end
        exp_q.push_back(32'd1);
        bus_read(A_CLAIM, rd);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL level_claim: got %h, expected %h", rd, exp);
        end
        tests++;
        if (int_flag_o !== '0 || dbg_state_o !== 2'd2) begin
            fails++;
            $display("FAIL level_claimed: flag=%h state=%0d, expected flag=0 state=2",
                     int_flag_o, dbg_state_o);
        end
        bus_write(A_CLAIM, 32'd1);
        @(negedge clk);
        tests++;
        if (int_flag_o !== 14'h0001) begin
            fails++;
            $display("FAIL level_reassert: got %h, expected 0001", int_flag_o);
        end
        irq_src_i[0] = 1'b0;
    endtask

    task automatic test_edge();
        logic [31:0] rd, exp;
        apply_reset();
        bus_write(A_TRIGGER, 32'h0020);
        bus_write(A_ENABLE, 32'h0020);
        irq_src_i[5] = 1'b1;
        @(negedge clk);
        irq_src_i[5] = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (int_flag_o !== 14'h0020) begin
            fails++;
            $display("FAIL edge_flag: got %h, expected 0020", int_flag_o);
        end
        exp_q.push_back(32'h0020);
        exp_q.push_back(32'd6);
        exp_q.push_back(32'h0000);
        bus_read(A_PENDING, rd);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL edge_pending: got %h, expected %h", rd, exp);
        end
        bus_read(A_CLAIM, rd);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL edge_claim: got %h, expected %h", rd, exp);
        end
        bus_read(A_PENDING, rd);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL edge_pending_cleared: got %h, expected %h", rd, exp);
        end
        bus_write(A_CLAIM, 32'd6);
        @(negedge clk);
        tests++;
        if (int_flag_o !== '0 || dbg_state_o !== 2'd0) begin
            fails++;
            $display("FAIL edge_complete: flag=%h state=%0d, expected flag=0 state=0",
                     int_flag_o, dbg_state_o);
        end
    endtask

    task automatic test_priority();
        logic [31:0] rd, exp;
        apply_reset();
        bus_write(A_TRIGGER, 32'h3FFF);
        bus_write(A_ENABLE, 32'h3FFF);
        irq_src_i[9] = 1'b1;
        irq_src_i[3] = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if (int_flag_o !== 14'h0008) begin
            fails++;
            $display("FAIL prio_flag: got %h, expected 0008", int_flag_o);
        end
        exp_q.push_back(32'd4);
        bus_read(A_CLAIM, rd);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL prio_claim_first: got %h, expected %h", rd, exp);
        end
        // Wrong completion ID must be ignored.
        bus_write(A_CLAIM, 32'd7);
        @(negedge clk);
        tests++;
        if (int_flag_o !== '0 || dbg_state_o !== 2'd2) begin
            fails++;
            $display("FAIL mismatch_complete: flag=%h state=%0d, expected flag=0 state=2",
                     int_flag_o, dbg_state_o);
        end
        bus_write(A_CLAIM, 32'd4);
        tests++;
        if (dbg_state_o !== 2'd0) begin
            fails++;
            $display("FAIL match_complete: state=%0d, expected 0", dbg_state_o);
        end
        @(negedge clk);
        tests++;
        if (int_flag_o !== 14'h0200) begin
            fails++;
            $display("FAIL prio_second_flag: got %h, expected 0200", int_flag_o);
        end
        exp_q.push_back(32'd10);
        bus_read(A_CLAIM, rd);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL prio_claim_second: got %h, expected %h", rd, exp);
        end
        bus_write(A_CLAIM, 32'd10);
        irq_src_i = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd, exp;
        apply_reset();
        bus_write(A_TRIGGER, 32'h0004);
        irq_src_i[2] = 1'b1;
        @(negedge clk);
        irq_src_i[2] = 1'b0;
        repeat (4) @(negedge clk);
        bus_write(A_PENDING, 32'h0004);
        exp_q.push_back(32'h0000);
        bus_read(A_PENDING, rd);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL w1c_plain: got %h, expected %h", rd, exp);
        end
        // New edge lands on the same clock edge as the W1C write.
        irq_src_i[2] = 1'b1;
        repeat (SYNC) @(negedge clk);
        bus_write(A_PENDING, 32'h0004);
        exp_q.push_back(32'h0004);
        bus_read(A_PENDING, rd);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL w1c_race: got %h, expected %h", rd, exp);
        end
    endtask

    task automatic test_disable();
        // PENDING[2] is left set by the previous scenario.
        bus_write(A_ENABLE, 32'h0004);
        @(negedge clk);
        tests++;
        if (int_flag_o !== 14'h0004 || dbg_state_o !== 2'd1) begin
            fails++;
            $display("FAIL disable_pre: flag=%h state=%0d, expected flag=0004 state=1",
                     int_flag_o, dbg_state_o);
        end
        bus_write(A_ENABLE, 32'h0000);
        @(negedge clk);
        tests++;
        if (int_flag_o !== '0 || dbg_state_o !== 2'd0) begin
            fails++;
            $display("FAIL disable_idle: flag=%h state=%0d, expected flag=0 state=0",
                     int_flag_o, dbg_state_o);
        end
        irq_src_i = '0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp;
        apply_reset();
        bus_write(A_ENABLE, 32'h0001);
        irq_src_i[0] = 1'b1;
        repeat (LAT_IDLE + 2) @(negedge clk);
        bus_read(A_CLAIM, rd);
        tests++;
        if (rd !== 32'd1 || dbg_state_o !== 2'd2) begin
            fails++;
            $display("FAIL midrst_setup: claim=%h state=%0d, expected claim=1 state=2",
                     rd, dbg_state_o);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (int_flag_o !== '0 || ack_o !== 1'b0 || rdata_o !== '0 || dbg_state_o !== 2'd0) begin
            fails++;
            $display("FAIL midrst_async: flag=%h ack=%b rdata=%h state=%0d, expected all 0",
                     int_flag_o, ack_o, rdata_o, dbg_state_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(32'h0000);
        bus_read(A_ENABLE, rd);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL midrst_enable: got %h, expected %h", rd, exp);
        end
        repeat (LAT_IDLE + 3) @(negedge clk);
        tests++;
        if (int_flag_o !== '0) begin
            fails++;
            $display("FAIL midrst_quiet: got %h, expected 0", int_flag_o);
        end
        irq_src_i = '0;
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        tests    = 0;
        fails    = 0;
        last_ack = 1'b0;
        test_reset();
        test_level();
        test_edge();
        test_priority();
        test_w1c_race();
        test_disable();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
